imem_loader: RTL

Boot-time writer for the instruction memory. Receives a byte stream (count header, big-endian instruction words, XOR checksum) over a valid/ready handshake, assembles 32-bit words, and drives the instruction memory's write port one word per beat. It holds the processor core in reset until a complete image with a correct checksum has been written. It sits between the host/UART byte source and the instruction memory, on the write side of the port the program counter reads.

---
 rtl/imem_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// =============================================================================
// Module   : imem_loader
// Brief    : Boot-time loader that streams a checksummed byte image into the
//            instruction memory and holds the core in reset until it succeeds.
// Revision : 1.0
// =============================================================================
`default_nettype none

module imem_loader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          restart,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [31:0]   wr_data,
    output logic          core_rst,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_LOAD = 3'd1,
        S_CHK  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [7:0] c_depth = 8'(DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_ready_st;

    logic [7:0]    r_count;
    logic [7:0]    r_wcnt;
    logic [7:0]    r_xor;
    logic [1:0]    r_bidx;
    logic [23:0]   r_shift;

    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [31:0]   r_wr_data;
    logic          r_core_rst;
    logic          r_done;
    logic          r_err;

    logic          w_hdr_bad;
    logic          w_word_end;
    logic          w_last_word;

    assign w_hdr_bad   = (in_data == 8'd0) || (in_data > c_depth);
    assign w_word_end  = (r_bidx == 2'd3);
    assign w_last_word = ((r_wcnt + 8'd1) == r_count);

    // Inside the accepting states in_ready is 1, so in_valid alone marks a transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_ready_st  = 1'b0;
        unique case (r_state)
            S_HDR: begin
                w_ready_st = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_hdr_bad ? S_ERR : S_LOAD;
                end
            end
            S_LOAD: begin
                w_ready_st = 1'b1;
                if (in_valid && w_word_end && w_last_word) begin
                    w_state_nxt = S_CHK;
                end
            end
            S_CHK: begin
                w_ready_st = 1'b1;
                if (in_valid) begin
                    w_state_nxt = (in_data == r_xor) ? S_DONE : S_ERR;
                end
            end
            S_DONE, S_ERR: begin
                if (restart) begin
                    w_state_nxt = S_HDR;
                end
            end
            default: w_state_nxt = S_HDR;
        endcase
    end

    // Masked by rst so the source sees no ready while the loader is held in reset.
    assign in_ready = w_ready_st & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= 8'd0;
            r_wcnt    <= 8'd0;
            r_xor     <= 8'd0;
            r_bidx    <= 2'd0;
            r_shift   <= 24'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= 32'd0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_HDR: begin
                    if (in_valid && !w_hdr_bad) begin
                        r_count <= in_data;
                        r_xor   <= in_data;
                        r_wcnt  <= 8'd0;
                        r_bidx  <= 2'd0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        r_xor   <= r_xor ^ in_data;
                        r_shift <= {r_shift[15:0], in_data};
                        r_bidx  <= r_bidx + 2'd1;
                        if (w_word_end) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= AW'(r_wcnt);
                            r_wr_data <= {r_shift, in_data};
                            r_wcnt    <= r_wcnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags follow the next state so they are valid the cycle after the deciding edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_core_rst <= (w_state_nxt != S_DONE);
            r_done     <= (w_state_nxt == S_DONE);
            r_err      <= (w_state_nxt == S_ERR);
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign core_rst = r_core_rst;
    assign done     = r_done;
    assign err      = r_err;

endmodule

`default_nettype wire
